demux_fifo_1x2: RTL and testbench

DEMUX_FIFO_1X2 -- requirements
Module: demux_fifo_1x2

---
 rtl/demux_fifo_1x2.sv | 147 ++++++++++++++
 tb/tb_demux_fifo_1x2.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_fifo_1x2.sv
// demux_fifo_1x2: splits one word stream into two lane FIFOs, alternating lanes.
// Ports: clk, reset, valid_in, data_in, pop_0/1, data_out_0/1, valid_out_0/1,
//        empty_0/1, full_0/1, overflow.

// demux_fifo_lane: one circular FIFO lane with a registered pop output.
// Ports: clk, reset, push, pop, data_in, data_out, valid_out, empty, full, drop.
module demux_fifo_lane #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              empty,
    output logic              full,
    output logic              drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nx;
    logic              pop_ok;
    logic              wr_ok;

    // A pop frees the head slot in the same edge, so a full lane can
    // still take a word when it is popped at the same time.
    assign pop_ok = pop && !empty;
    assign wr_ok  = push && (!full || pop_ok);
    assign drop   = push && full && !pop_ok;

    always_comb begin
        count_nx = count + CW'(wr_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count_nx;
            empty <= (count_nx == '0);
            full  <= (count_nx == FULL_CNT);
        end
    end

    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end
endmodule

module demux_fifo_1x2 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop_0,
    input  logic              pop_1,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_0,
    output logic              valid_out_1,
    output logic              empty_0,
    output logic              empty_1,
    output logic              full_0,
    output logic              full_1,
    output logic              overflow
);
    logic sel;
    logic drop_0;
    logic drop_1;

    // sel flips on every valid word, dropped ones included, so lane
    // assignment always follows arrival parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (valid_in) begin
                sel <= ~sel;
            end
            if (drop_0 || drop_1) begin
                overflow <= 1'b1;
            end
        end
    end

    demux_fifo_lane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane_0 (
        .clk       (clk),
        .reset     (reset),
        .push      (valid_in && !sel),
        .pop       (pop_0),
        .data_in   (data_in),
        .data_out  (data_out_0),
        .valid_out (valid_out_0),
        .empty     (empty_0),
        .full      (full_0),
        .drop      (drop_0)
    );

    demux_fifo_lane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_lane_1 (
        .clk       (clk),
        .reset     (reset),
        .push      (valid_in && sel),
        .pop       (pop_1),
        .data_in   (data_in),
        .data_out  (data_out_1),
        .valid_out (valid_out_1),
        .empty     (empty_1),
        .full      (full_1),
        .drop      (drop_1)
    );
endmodule

// File: tb/tb_demux_fifo_1x2.sv
// tb_demux_fifo_1x2: directed self-checking bench for demux_fifo_1x2.
// Drives inputs 1ns after each rising edge and checks 1ns after the next.
module tb_demux_fifo_1x2;
    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       pop_0;
    logic       pop_1;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       empty_0;
    logic       empty_1;
    logic       full_0;
    logic       full_1;
    logic       overflow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    demux_fifo_1x2 #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .pop_0       (pop_0),
        .pop_1       (pop_1),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .empty_0     (empty_0),
        .empty_1     (empty_1),
        .full_0      (full_0),
        .full_1      (full_1),
        .overflow    (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] d);
        valid_in = 1'b1;
        data_in  = d;
        step();
        valid_in = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        pop_0    = 1'b0;
        pop_1    = 1'b0;
        step();
        step();
        chk("rst_empty_0", empty_0, 1);
        chk("rst_empty_1", empty_1, 1);
        chk("rst_full_0", full_0, 0);
        chk("rst_full_1", full_1, 0);
        chk("rst_vout_0", valid_out_0, 0);
        chk("rst_vout_1", valid_out_1, 0);
        chk("rst_dout_0", data_out_0, 0);
        chk("rst_dout_1", data_out_1, 0);
        chk("rst_ovf", overflow, 0);

        // Interleave
        reset = 1'b0;
        push(8'hAC);
        chk("push_lat_empty_0", empty_0, 0);
        chk("push_lat_empty_1", empty_1, 1);
        push(8'hFF);
        push(8'hDC);
        push(8'hEE);
        chk("il_full_0", full_0, 0);
        pop_0 = 1'b1;
        pop_1 = 1'b1;
        step();
        chk("il_vout_0a", valid_out_0, 1);
        chk("il_dout_0a", data_out_0, 8'hAC);
        chk("il_vout_1a", valid_out_1, 1);
        chk("il_dout_1a", data_out_1, 8'hFF);
        step();
        chk("il_dout_0b", data_out_0, 8'hDC);
        chk("il_dout_1b", data_out_1, 8'hEE);
        pop_0 = 1'b0;
        pop_1 = 1'b0;
        step();
        chk("il_idle_vout_0", valid_out_0, 0);
        chk("il_hold_dout_0", data_out_0, 8'hDC);
        chk("il_empty_0", empty_0, 1);
        chk("il_empty_1", empty_1, 1);

        // Gaps do not move the lane selector
        push(8'h01);
        data_in = 8'h33;
        step();
        step();
        push(8'h02);
        pop_0 = 1'b1;
        pop_1 = 1'b1;
        step();
        chk("gap_dout_0", data_out_0, 8'h01);
        chk("gap_dout_1", data_out_1, 8'h02);
        pop_0 = 1'b0;
        step();
        chk("gap_empty_0", empty_0, 1);

        // Underflow on lane 1 (pop_1 still high, lane empty)
        step();
        chk("uf_vout_1", valid_out_1, 0);
        chk("uf_dout_1", data_out_1, 8'h02);
        chk("uf_empty_1", empty_1, 1);
        pop_1 = 1'b0;

        // Overflow: 10 words, no pops
        for (int i = 0; i < 10; i++) begin
            push(8'(i));
        end
        chk("ovf_full_0", full_0, 1);
        chk("ovf_full_1", full_1, 1);
        chk("ovf_flag", overflow, 1);
        pop_0 = 1'b1;
        pop_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ovf_dout_0", data_out_0, 8'(2 * i));
            chk("ovf_dout_1", data_out_1, 8'(2 * i + 1));
        end
        pop_0 = 1'b0;
        pop_1 = 1'b0;
        push(8'hA5);
        chk("ovf_sel_empty_1", empty_1, 1);
        chk("ovf_sticky", overflow, 1);
        pop_0 = 1'b1;
        step();
        pop_0 = 1'b0;
        chk("ovf_sel_dout_0", data_out_0, 8'hA5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Push and pop together on a full lane
        for (int i = 0; i < 8; i++) begin
            push(8'(i));
        end
        chk("fpp_full_0_pre", full_0, 1);
        valid_in = 1'b1;
        data_in  = 8'h08;
        pop_0    = 1'b1;
        step();
        valid_in = 1'b0;
        chk("fpp_dout_0", data_out_0, 8'h00);
        chk("fpp_vout_0", valid_out_0, 1);
        chk("fpp_full_0", full_0, 1);
        chk("fpp_ovf", overflow, 0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("fpp_drain_0", data_out_0, 8'(2 * i));
        end
        pop_0 = 1'b0;
        step();
        chk("fpp_empty_0", empty_0, 1);
        chk("fpp_full_1", full_1, 1);
        chk("fpp_vout_1", valid_out_1, 0);

        // Reset mid-stream, overriding a concurrent word
        reset = 1'b1;
        step();
        reset = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'h55;
        step();
        reset    = 1'b0;
        valid_in = 1'b0;
        chk("rms_empty_0", empty_0, 1);
        chk("rms_empty_1", empty_1, 1);
        chk("rms_ovf", overflow, 0);
        chk("rms_vout_0", valid_out_0, 0);
        chk("rms_vout_1", valid_out_1, 0);
        push(8'h66);
        chk("rms_66_empty_0", empty_0, 0);
        chk("rms_66_empty_1", empty_1, 1);
        pop_0 = 1'b1;
        step();
        pop_0 = 1'b0;
        chk("rms_66_dout_0", data_out_0, 8'h66);

        // Push and pop together with one entry in the lane
        push(8'h90);
        push(8'h91);
        valid_in = 1'b1;
        data_in  = 8'h92;
        pop_1    = 1'b1;
        step();
        valid_in = 1'b0;
        chk("c1_dout_1", data_out_1, 8'h90);
        chk("c1_empty_1", empty_1, 0);
        step();
        pop_1 = 1'b0;
        chk("c1_dout_1b", data_out_1, 8'h92);
        step();
        chk("c1_empty_1b", empty_1, 1);
        chk("c1_empty_0", empty_0, 0);
        pop_0 = 1'b1;
        step();
        pop_0 = 1'b0;
        chk("c1_dout_0", data_out_0, 8'h91);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
